fp_compare_unit: RTL
====================

Name: fp_compare_unit

Overview:
- Pipelined floating-point compare stage that feeds the integer writeback path.
- Accepts FEQ, FLT and FLE requests on a valid/ready handshake and produces the 0/1 integer result, zero-extended to BUS_WIDTH.
- Produces the per-op invalid flag (NV) and keeps a sticky accrued NV bit.
- Sits between FPU issue and the register-file writeback arbiter; it is the sequenced, handshaked wrapper around the combinational less-than/equal logic.

Parameters:
- BUS_WIDTH, 64, operand width; 64 selects double (11-bit exponent, 52-bit mantissa), 32 selects single (8-bit exponent, 23-bit mantissa).
- TAG_WIDTH, 5, width of the destination-register tag carried alongside each request.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  request present.
- in_ready  output  1  unit can accept a request this cycle.
- in_op  input  2  operation: 00 FEQ, 01 FLT, 10 FLE, 11 reserved.
- in_a  input  BUS_WIDTH  operand rs1.
- in_b  input  BUS_WIDTH  operand rs2.
- in_tag  input  TAG_WIDTH  destination tag.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts the result.
- out_result  output  BUS_WIDTH  0 or 1, zero-extended.
- out_tag  output  TAG_WIDTH  tag of this result.
- out_nv  output  1  invalid flag for this result.
- nv_sticky  output  1  accrued NV.
- nv_clear  input  1  clears nv_sticky.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Pipeline: two registered stages.
  - S1 captures the operands, op and tag, plus a classification: isNaN, isSNaN, isZero and sign for each operand.
  - S2 holds the computed result, tag and nv.
  - Each stage has its own valid bit.
- Latency: 2 cycles from the accepting edge to out_valid, with no backpressure.
- Throughput: 1 request per cycle.
- Handshake:
  - Transfer on the input occurs when in_valid and in_ready are both high at a rising edge.
  - Transfer on the output occurs when out_valid and out_ready are both high.
  - s2_advance = !s2_valid | out_ready.
  - s1_advance = !s1_valid | s2_advance.
  - in_ready = s1_advance. It is combinational from out_ready; there is no combinational path from in_valid to in_ready.
- Output stability: while out_valid=1 and out_ready=0, out_result, out_tag and out_nv are held stable.
- Classification:
  - NaN = exponent all ones with a non-zero mantissa.
  - sNaN = NaN with mantissa MSB equal to 0.
  - Zero = all bits except the sign equal to 0.
- Comparison:
  - +0 and -0 compare equal.
  - Ordered less-than uses sign/magnitude:
    - Signs differ: a<b iff a is negative and the pair is not both-zero.
    - Both positive: a<b iff magnitude(a) < magnitude(b).
    - Both negative: a<b iff magnitude(a) > magnitude(b).
- Results:
  - FEQ = equal, and 0 if either operand is NaN.
  - FLT = a<b, and 0 if either operand is NaN.
  - FLE = a<b or equal, and 0 if either operand is NaN.
- NV generation:
  - FEQ: NV=1 iff either operand is an sNaN.
  - FLT / FLE: NV=1 iff either operand is any NaN.
  - Reserved op 11: result 0, NV=0. It still flows through the pipeline and handshakes normally.
- nv_sticky:
  - Set when an output transfer occurs with out_nv=1.
  - Cleared when nv_clear=1.
  - If a set and nv_clear=1 occur in the same cycle, the set wins and nv_sticky ends at 1.
- Reset: s1_valid, s2_valid, out_valid and nv_sticky are all 0, and out_result, out_tag and out_nv are 0. in_ready is 1 in the first cycle after reset.
- Reset mid-operation: in-flight requests are discarded and no output transfer occurs for them.
- Full pipeline: with both stages valid and out_ready=0, in_ready=0 and no state changes.
- Simultaneous drain and fill: when out_ready=1 with the pipeline full, S2 takes S1 and S1 takes the new request in the same edge. No bubble and no loss.

Test Plan:
- Ordered compares, BUS_WIDTH=64: FLT a=3FF0000000000000 (1.0), b=4000000000000000 (2.0) -> out_result=1, out_nv=0, out_valid exactly 2 cycles after acceptance. FLE a=b=4000000000000000 -> 1. FEQ with 1.0/2.0 -> 0.
- Signed zero and negatives: FEQ a=8000000000000000, b=0 -> 1. FLT a=-0, b=+0 -> 0. FLT a=BFF0000000000000 (-1.0), b=C000000000000000 (-2.0) -> 0. FLT with operands swapped -> 1.
- NaN rules: FEQ a=7FF8000000000000 (qNaN), b=1.0 -> result 0, nv 0. FEQ with a=7FF0000000000001 (sNaN) -> nv 1. FLT with a=qNaN -> result 0, nv 1. nv_sticky rises the cycle after that output transfer.
- Backpressure: issue 4 back-to-back requests with distinct tags 1..4 and hold out_ready=0. Required: in_ready drops after 2 acceptances; out_* stay stable while stalled. Then raise out_ready: all 4 results drain in order 1,2,3,4 with one per cycle, and nothing is lost or duplicated.
- Sticky and clear priority: assert nv_clear in the same cycle as an NV=1 output transfer -> nv_sticky=1. nv_clear alone on the next cycle -> nv_sticky=0.
- Reset mid-flight: accept 2 requests, assert rst for 1 cycle -> out_valid=0, nv_sticky=0, in_ready=1 after reset, and no stale result appears afterwards.
- BUS_WIDTH=32 smoke test: FLT a=3F800000, b=40000000 -> 1. FLE a=7FC00000 (qNaN), b=0 -> result 0, nv 1.

Source files
------------

// File: rtl/fp_compare_unit.sv
// Two-stage pipelined FEQ/FLT/FLE compare with valid/ready handshake.
// S1 registers operands plus classification; S2 registers result, tag and NV.
module fp_compare_unit #(
  parameter int BUS_WIDTH = 64,
  parameter int TAG_WIDTH = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           in_op,
  input  logic [BUS_WIDTH-1:0] in_a,
  input  logic [BUS_WIDTH-1:0] in_b,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out_result,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 out_nv,
  output logic                 nv_sticky,
  input  logic                 nv_clear
);

  localparam int EXP_W = (BUS_WIDTH == 32) ? 8 : 11;
  localparam int MAN_W = BUS_WIDTH - 1 - EXP_W;

  localparam logic [1:0] OP_FEQ = 2'b00;
  localparam logic [1:0] OP_FLT = 2'b01;
  localparam logic [1:0] OP_FLE = 2'b10;

  // S1 state
  logic                 s1_valid_q, s1_valid_d;
  logic [1:0]           s1_op_q, s1_op_d;
  logic [BUS_WIDTH-1:0] s1_a_q, s1_a_d;
  logic [BUS_WIDTH-1:0] s1_b_q, s1_b_d;
  logic [TAG_WIDTH-1:0] s1_tag_q, s1_tag_d;
  logic                 s1_a_nan_q, s1_a_nan_d, s1_a_snan_q, s1_a_snan_d;
  logic                 s1_a_zero_q, s1_a_zero_d, s1_a_sign_q, s1_a_sign_d;
  logic                 s1_b_nan_q, s1_b_nan_d, s1_b_snan_q, s1_b_snan_d;
  logic                 s1_b_zero_q, s1_b_zero_d, s1_b_sign_q, s1_b_sign_d;

  // S2 state
  logic                 s2_valid_q, s2_valid_d;
  logic                 s2_result_q, s2_result_d;
  logic [TAG_WIDTH-1:0] s2_tag_q, s2_tag_d;
  logic                 s2_nv_q, s2_nv_d;
  logic                 nv_sticky_q, nv_sticky_d;

  logic s1_advance, s2_advance;

  logic [EXP_W-1:0]     a_exp, b_exp;
  logic [MAN_W-1:0]     a_man, b_man;
  logic [BUS_WIDTH-2:0] mag_a, mag_b;
  logic                 both_zero, any_nan, any_snan, is_equal, is_less;
  logic                 cmp_result, cmp_nv;

  assign s2_advance = !s2_valid_q || out_ready;
  assign s1_advance = !s1_valid_q || s2_advance;
  assign in_ready   = s1_advance;

  assign out_valid  = s2_valid_q;
  assign out_result = {{(BUS_WIDTH-1){1'b0}}, s2_result_q};
  assign out_tag    = s2_tag_q;
  assign out_nv     = s2_nv_q;
  assign nv_sticky  = nv_sticky_q;

  assign a_exp = in_a[BUS_WIDTH-2 -: EXP_W];
  assign b_exp = in_b[BUS_WIDTH-2 -: EXP_W];
  assign a_man = in_a[MAN_W-1:0];
  assign b_man = in_b[MAN_W-1:0];

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_op_d     = s1_op_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_tag_d    = s1_tag_q;
    s1_a_nan_d  = s1_a_nan_q;
    s1_a_snan_d = s1_a_snan_q;
    s1_a_zero_d = s1_a_zero_q;
    s1_a_sign_d = s1_a_sign_q;
    s1_b_nan_d  = s1_b_nan_q;
    s1_b_snan_d = s1_b_snan_q;
    s1_b_zero_d = s1_b_zero_q;
    s1_b_sign_d = s1_b_sign_q;
    if (s1_advance) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_op_d     = in_op;
        s1_a_d      = in_a;
        s1_b_d      = in_b;
        s1_tag_d    = in_tag;
        s1_a_nan_d  = (&a_exp) && (|a_man);
        s1_a_snan_d = (&a_exp) && (|a_man) && !a_man[MAN_W-1];
        s1_a_zero_d = ~|in_a[BUS_WIDTH-2:0];
        s1_a_sign_d = in_a[BUS_WIDTH-1];
        s1_b_nan_d  = (&b_exp) && (|b_man);
        s1_b_snan_d = (&b_exp) && (|b_man) && !b_man[MAN_W-1];
        s1_b_zero_d = ~|in_b[BUS_WIDTH-2:0];
        s1_b_sign_d = in_b[BUS_WIDTH-1];
      end
    end
  end

  // Sign/magnitude ordering; both-zero covers the +0 == -0 case.
  always_comb begin
    mag_a     = s1_a_q[BUS_WIDTH-2:0];
    mag_b     = s1_b_q[BUS_WIDTH-2:0];
    both_zero = s1_a_zero_q && s1_b_zero_q;
    any_nan   = s1_a_nan_q || s1_b_nan_q;
    any_snan  = s1_a_snan_q || s1_b_snan_q;
    is_equal  = both_zero || (s1_a_q == s1_b_q);
    if (s1_a_sign_q != s1_b_sign_q)
      is_less = s1_a_sign_q && !both_zero;
    else if (!s1_a_sign_q)
      is_less = mag_a < mag_b;
    else
      is_less = mag_a > mag_b;
    cmp_result = 1'b0;
    cmp_nv     = 1'b0;
    case (s1_op_q)
      OP_FEQ: begin
        cmp_result = is_equal && !any_nan;
        cmp_nv     = any_snan;
      end
      OP_FLT: begin
        cmp_result = is_less && !any_nan;
        cmp_nv     = any_nan;
      end
      OP_FLE: begin
        cmp_result = (is_less || is_equal) && !any_nan;
        cmp_nv     = any_nan;
      end
      default: begin
        cmp_result = 1'b0;
        cmp_nv     = 1'b0;
      end
    endcase
  end

  always_comb begin
    s2_valid_d  = s2_valid_q;
    s2_result_d = s2_result_q;
    s2_tag_d    = s2_tag_q;
    s2_nv_d     = s2_nv_q;
    nv_sticky_d = nv_sticky_q;
    if (s2_advance) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_result_d = cmp_result;
        s2_tag_d    = s1_tag_q;
        s2_nv_d     = cmp_nv;
      end
    end
    // A flagged transfer outranks a simultaneous clear.
    if (s2_valid_q && out_ready && s2_nv_q)
      nv_sticky_d = 1'b1;
    else if (nv_clear)
      nv_sticky_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_op_q     <= '0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_tag_q    <= '0;
      s1_a_nan_q  <= 1'b0;
      s1_a_snan_q <= 1'b0;
      s1_a_zero_q <= 1'b0;
      s1_a_sign_q <= 1'b0;
      s1_b_nan_q  <= 1'b0;
      s1_b_snan_q <= 1'b0;
      s1_b_zero_q <= 1'b0;
      s1_b_sign_q <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_result_q <= 1'b0;
      s2_tag_q    <= '0;
      s2_nv_q     <= 1'b0;
      nv_sticky_q <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_op_q     <= s1_op_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_tag_q    <= s1_tag_d;
      s1_a_nan_q  <= s1_a_nan_d;
      s1_a_snan_q <= s1_a_snan_d;
      s1_a_zero_q <= s1_a_zero_d;
      s1_a_sign_q <= s1_a_sign_d;
      s1_b_nan_q  <= s1_b_nan_d;
      s1_b_snan_q <= s1_b_snan_d;
      s1_b_zero_q <= s1_b_zero_d;
      s1_b_sign_q <= s1_b_sign_d;
      s2_valid_q  <= s2_valid_d;
      s2_result_q <= s2_result_d;
      s2_tag_q    <= s2_tag_d;
      s2_nv_q     <= s2_nv_d;
      nv_sticky_q <= nv_sticky_d;
    end
  end

endmodule
